// File: rtl/clkdiv_seq_ctrl.sv
// Divider sequencer: handshaked half-period config applied only at period
// boundaries, continuous or N-pulse burst generation with graceful stop.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | CLK_Out held low; pending config applied on the next edge
// RUN      | counting half-periods, toggling CLK_Out, counting rises
// STOPPING | stop seen with CLK_Out high; finish the high phase, then IDLE
module clkdiv_seq_ctrl #(
  parameter int CNT_W    = 25,
  parameter int PULSE_W  = 8,
  parameter int DEF_HALF = 25000000
) (
  input  logic               CLK_IN,
  input  logic               nCLR,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic               cfg_burst,
  input  logic [PULSE_W-1:0] cfg_pulses,
  input  logic               start,
  input  logic               stop,
  output logic               CLK_Out,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam logic [CNT_W-1:0]   HALF_RST = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PULSE_W-1:0] PCNT_MAX = '1;
  localparam logic [PULSE_W-1:0] PCNT_ONE = PULSE_W'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PULSE_W-1:0]   pcnt_q, pcnt_d;
  logic                 clk_out_q, clk_out_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 pend_q, pend_d;
  logic [CNT_W-1:0]     sh_half_q, sh_half_d;
  logic                 sh_burst_q, sh_burst_d;
  logic [PULSE_W-1:0]   sh_pulses_q, sh_pulses_d;
  logic [CNT_W-1:0]     act_half_q, act_half_d;
  logic                 act_burst_q, act_burst_d;
  logic [PULSE_W-1:0]   act_pulses_q, act_pulses_d;

  logic                 at_tc;
  logic                 apply;
  logic                 eff_burst;
  logic [PULSE_W-1:0]   eff_pulses;
  logic [CNT_W-1:0]     cnt_inc;

  assign at_tc      = (cnt_q == act_half_q - CNT_ONE);
  assign cnt_inc    = cnt_q + CNT_ONE;
  // A start in IDLE sees the config that is being applied on that same edge.
  assign eff_burst  = pend_q ? sh_burst_q  : act_burst_q;
  assign eff_pulses = pend_q ? sh_pulses_q : act_pulses_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pcnt_d       = pcnt_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    pend_d       = pend_q;
    sh_half_d    = sh_half_q;
    sh_burst_d   = sh_burst_q;
    sh_pulses_d  = sh_pulses_q;
    act_half_d   = act_half_q;
    act_burst_d  = act_burst_q;
    act_pulses_d = act_pulses_q;
    apply        = 1'b0;

    case (state_q)
      IDLE: begin
        apply = pend_q;
        if (start && !stop) begin
          if (eff_burst && (eff_pulses == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            pcnt_d  = '0;
          end
        end
      end
      RUN: begin
        if (at_tc && clk_out_q) begin
          clk_out_d = 1'b0;
          cnt_d     = '0;
          apply     = pend_q;
          if (act_burst_q && (pcnt_q >= act_pulses_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (stop) begin
            state_d = IDLE;
          end
        end else if (stop && !clk_out_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          apply   = pend_q;
        end else if (stop) begin
          state_d = STOPPING;
          cnt_d   = cnt_inc;
        end else if (at_tc) begin
          clk_out_d = 1'b1;
          cnt_d     = '0;
          tick_d    = 1'b1;
          if (pcnt_q != PCNT_MAX) pcnt_d = pcnt_q + PCNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STOPPING: begin
        if (at_tc) begin
          clk_out_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
          apply     = pend_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_out_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    if (apply) begin
      act_half_d   = sh_half_q;
      act_burst_d  = sh_burst_q;
      act_pulses_d = sh_pulses_q;
      pend_d       = 1'b0;
    end

    // Transfer and apply are exclusive: one needs pend_q low, the other high.
    if (cfg_valid && !pend_q) begin
      pend_d      = 1'b1;
      sh_half_d   = (cfg_half == '0) ? CNT_ONE : cfg_half;
      sh_burst_d  = cfg_burst;
      sh_pulses_d = cfg_pulses;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_IN or negedge nCLR) begin
    if (!nCLR) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pcnt_q       <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      pend_q       <= 1'b0;
      sh_half_q    <= CNT_ONE;
      sh_burst_q   <= 1'b0;
      sh_pulses_q  <= '0;
      act_half_q   <= HALF_RST;
      act_burst_q  <= 1'b0;
      act_pulses_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pcnt_q       <= pcnt_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      sh_half_q    <= sh_half_d;
      sh_burst_q   <= sh_burst_d;
      sh_pulses_q  <= sh_pulses_d;
      act_half_q   <= act_half_d;
      act_burst_q  <= act_burst_d;
      act_pulses_q <= act_pulses_d;
    end
  end

  assign cfg_ready = ~pend_q;
  assign CLK_Out   = clk_out_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Bench for clkdiv_seq_ctrl: directed table, hand-written corner sequences and
// random traffic against an elapsed-time reference model.
module tb_clkdiv_seq_ctrl;

  localparam int CNT_W   = 25;
  localparam int PULSE_W = 8;

  logic               CLK_IN = 1'b0;
  logic               nCLR   = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_half = '0;
  logic               cfg_burst = 1'b0;
  logic [PULSE_W-1:0] cfg_pulses = '0;
  logic               start = 1'b0;
  logic               stop  = 1'b0;
  logic               CLK_Out, tick, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  clkdiv_seq_ctrl #(.CNT_W(CNT_W), .PULSE_W(PULSE_W), .DEF_HALF(3)) dut (
    .CLK_IN(CLK_IN), .nCLR(nCLR),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_half(cfg_half),
    .cfg_burst(cfg_burst), .cfg_pulses(cfg_pulses),
    .start(start), .stop(stop),
    .CLK_Out(CLK_Out), .tick(tick), .busy(busy), .done(done)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Reference model: time measured as cycles elapsed since the period grid
  // was last anchored (start or a config apply); edges found by modulo.
  int m_mode;   // 0 idle, 1 run, 2 stopping
  int m_e, m_half, m_n, m_rises, s_half, s_n;
  bit m_burst, m_pend, s_burst, m_clk, m_tick, m_done;

  task automatic model_reset();
    m_mode = 0; m_e = 0; m_half = 3; m_n = 0; m_burst = 0; m_rises = 0;
    m_pend = 0; s_half = 1; s_n = 0; s_burst = 0;
    m_clk = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_apply();
    m_half = s_half; m_burst = s_burst; m_n = s_n; m_pend = 0; m_e = 0;
  endtask

  task automatic model_edge();
    bit was_pend, xfer, fall, rise;
    int e;
    was_pend = m_pend;
    xfer = cfg_valid && !m_pend;
    m_tick = 0;
    m_done = 0;
    if (m_mode == 0) begin
      if (was_pend) model_apply();
      if (start && !stop) begin
        if (m_burst && m_n == 0) m_done = 1;
        else begin m_mode = 1; m_e = 0; m_rises = 0; end
      end
    end else begin
      e = m_e + 1;
      fall = (e % (2 * m_half)) == 0;
      rise = (e % (2 * m_half)) == m_half;
      if (fall) begin
        m_clk = 0;
        m_e = e;
        if (m_mode == 2) m_mode = 0;
        else if (m_burst && m_rises >= m_n) begin m_mode = 0; m_done = 1; end
        else if (stop) m_mode = 0;
        if (was_pend) model_apply();
      end else if (m_mode == 1 && stop) begin
        if (!m_clk) begin m_mode = 0; m_e = 0; if (was_pend) model_apply(); end
        else begin m_mode = 2; m_e = e; end
      end else if (rise) begin
        m_clk = 1; m_tick = 1; m_e = e;
        if (m_rises < 255) m_rises++;
      end else begin
        m_e = e;
      end
    end
    if (xfer) begin
      m_pend = 1;
      s_half = (cfg_half == 0) ? 1 : int'(cfg_half);
      s_burst = cfg_burst;
      s_n = int'(cfg_pulses);
    end
  endtask

  function automatic logic [4:0] outs();
    return {CLK_Out, tick, busy, done, cfg_ready};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    logic [4:0] exp;
    @(posedge CLK_IN);
    model_edge();
    #1;
    exp = {m_clk, m_tick, (m_mode != 0), m_done, !m_pend};
    chk("model{clk,tick,busy,done,ready}", 32'(outs()), 32'(exp));
  endtask

  task automatic wait_clk(input logic val, input string name);
    int i;
    i = 0;
    while (CLK_Out !== val && i < 60) begin step(); i++; end
    chk(name, 32'(CLK_Out), 32'(val));
  endtask

  task automatic send_cfg(input int h, input bit b, input int n);
    cfg_valid = 1; cfg_half = CNT_W'(h); cfg_burst = b; cfg_pulses = PULSE_W'(n);
    step();
    cfg_valid = 0;
  endtask

  typedef struct {
    logic start, stop, valid;
    int half;
    logic burst;
    int n;
    logic [4:0] exp;  // {CLK_Out, tick, busy, done, cfg_ready}
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic s, logic p, logic v, int h, logic b, int n, logic [4:0] x);
    vec_t r;
    r.start = s; r.stop = p; r.valid = v; r.half = h; r.burst = b; r.n = n; r.exp = x;
    return r;
  endfunction

  initial begin
    int tk;
    // default half 3: start, two periods, stop while high
    tbl[0]  = mk(1,0,0,0,0,0,5'b00101);
    tbl[1]  = mk(0,0,0,0,0,0,5'b00101);
    tbl[2]  = mk(0,0,0,0,0,0,5'b00101);
    tbl[3]  = mk(0,0,0,0,0,0,5'b11101);
    tbl[4]  = mk(0,0,0,0,0,0,5'b10101);
    tbl[5]  = mk(0,0,0,0,0,0,5'b10101);
    tbl[6]  = mk(0,0,0,0,0,0,5'b00101);
    tbl[7]  = mk(0,0,0,0,0,0,5'b00101);
    tbl[8]  = mk(0,0,0,0,0,0,5'b00101);
    tbl[9]  = mk(0,0,0,0,0,0,5'b11101);
    tbl[10] = mk(0,1,0,0,0,0,5'b10101);
    tbl[11] = mk(0,0,0,0,0,0,5'b10101);
    tbl[12] = mk(0,0,0,0,0,0,5'b00001);
    // burst half 2, N=3
    tbl[13] = mk(0,0,1,2,1,3,5'b00000);
    tbl[14] = mk(0,0,0,0,0,0,5'b00001);
    tbl[15] = mk(1,0,0,0,0,0,5'b00101);
    tbl[16] = mk(0,0,0,0,0,0,5'b00101);
    tbl[17] = mk(0,0,0,0,0,0,5'b11101);
    tbl[18] = mk(0,0,0,0,0,0,5'b10101);
    tbl[19] = mk(0,0,0,0,0,0,5'b00101);
    tbl[20] = mk(0,0,0,0,0,0,5'b00101);
    tbl[21] = mk(0,0,0,0,0,0,5'b11101);
    tbl[22] = mk(0,0,0,0,0,0,5'b10101);
    tbl[23] = mk(0,0,0,0,0,0,5'b00101);
    tbl[24] = mk(0,0,0,0,0,0,5'b00101);
    tbl[25] = mk(0,0,0,0,0,0,5'b11101);
    tbl[26] = mk(0,0,0,0,0,0,5'b10101);
    tbl[27] = mk(0,0,0,0,0,0,5'b00011);
    tbl[28] = mk(0,0,0,0,0,0,5'b00001);

    model_reset();
    repeat (3) @(posedge CLK_IN);
    #1;
    chk("reset_outputs", 32'(outs()), 32'(5'b00001));
    #2 nCLR = 1;

    foreach (tbl[i]) begin
      start = tbl[i].start; stop = tbl[i].stop; cfg_valid = tbl[i].valid;
      cfg_half = CNT_W'(tbl[i].half); cfg_burst = tbl[i].burst;
      cfg_pulses = PULSE_W'(tbl[i].n);
      step();
      chk($sformatf("table_row%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    start = 0; stop = 0; cfg_valid = 0;

    // reconfigure while running: old period completes, new one after the fall
    send_cfg(4, 0, 0);
    step();
    start = 1; step(); start = 0;
    wait_clk(1, "t3_first_rise");
    send_cfg(1, 0, 0);
    chk("t3_ready_low_r1", 32'(cfg_ready), 0);
    step(); chk("t3_ready_low_r2", 32'(cfg_ready), 0);
    step(); chk("t3_hold_high_r3", 32'({CLK_Out, cfg_ready}), 32'(2'b10));
    step(); chk("t3_fall_ready", 32'({CLK_Out, cfg_ready}), 32'(2'b01));
    step(); chk("t3_new_rise", 32'({CLK_Out, tick}), 32'(2'b11));
    step(); chk("t3_new_fall", 32'(CLK_Out), 0);
    step(); chk("t3_new_rise2", 32'({CLK_Out, tick}), 32'(2'b11));
    stop = 1; step(); stop = 0;
    chk("t3_stop_idle", 32'({busy, CLK_Out}), 0);

    // graceful stop while high, then stop while low
    send_cfg(5, 0, 0);
    step();
    start = 1; step(); start = 0;
    wait_clk(1, "t4_rise");
    step();
    stop = 1; step(); stop = 0;
    chk("t4_stopping", 32'({busy, CLK_Out}), 32'(2'b11));
    tk = 0;
    step(); tk += tick;
    step(); tk += tick;
    chk("t4_still_high", 32'(CLK_Out), 1);
    step(); tk += tick;
    chk("t4_fall_idle", 32'({CLK_Out, busy, done}), 0);
    step(); tk += tick;
    chk("t4_no_tick_done", 32'({tk[7:0], done}), 0);
    start = 1; step(); start = 0;
    wait_clk(1, "t4b_rise");
    wait_clk(0, "t4b_fall");
    stop = 1; step(); stop = 0;
    chk("t4b_stop_low", 32'({busy, CLK_Out, done}), 0);

    // start+stop together; burst with N=0
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("t5_start_stop", 32'({busy, CLK_Out}), 0);
    send_cfg(2, 1, 0);
    step();
    start = 1; step(); start = 0;
    chk("t5_n0_done", 32'({done, busy, CLK_Out}), 32'(3'b100));
    step(); chk("t5_n0_after", 32'({done, busy, CLK_Out}), 0);
    step(); chk("t5_n0_quiet", 32'(CLK_Out), 0);

    // async reset mid-burst with a pending config
    send_cfg(2, 1, 4);
    step();
    start = 1; step(); start = 0;
    wait_clk(1, "t6_rise");
    send_cfg(7, 0, 0);
    chk("t6_pending", 32'(cfg_ready), 0);
    #2 nCLR = 0;
    #1 chk("t6_async_reset", 32'(outs()), 32'(5'b00001));
    model_reset();
    repeat (2) @(posedge CLK_IN);
    #3 nCLR = 1;
    start = 1; step(); start = 0;
    step(); step();
    chk("t6_def_half_low", 32'(CLK_Out), 0);
    step();
    chk("t6_def_half_rise", 32'({CLK_Out, tick}), 32'(2'b11));

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_half   = CNT_W'($urandom_range(0, 4));
      cfg_burst  = 1'($urandom_range(0, 1));
      cfg_pulses = PULSE_W'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clkdiv_seq_ctrl.md
Name: clkdiv_seq_ctrl

Overview:
Programmable divider controller that sequences and reconfigures the team's divide-by-counter clock generation.
- Accepts new half-period settings over a valid/ready handshake.
- Applies new settings only at period boundaries, so no runt or mixed periods appear.
- Runs in continuous or N-pulse burst mode under start/stop control.
- Sits between control logic (keypad/FSM/CPU-style master) and downstream logic clocked or enabled by CLK_Out/tick.

Parameters:
CNT_W, 25, counter/half-period width in bits
PULSE_W, 8, burst pulse counter width
DEF_HALF, 25000000, half-period loaded at reset (1 Hz from 50 MHz)

Ports:
CLK_IN  input  1  system clock, all logic on rising edge
nCLR  input  1  asynchronous active-low reset
cfg_valid  input  1  config offer
cfg_ready  output  1  config can be accepted this cycle
cfg_half  input  CNT_W  requested half-period in CLK_IN cycles
cfg_burst  input  1  1 = burst mode, 0 = continuous
cfg_pulses  input  PULSE_W  burst length N
start  input  1  begin generation (level sampled per cycle)
stop  input  1  request graceful stop
CLK_Out  output  1  divided output, registered
tick  output  1  one-cycle pulse coincident with each CLK_Out rise
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of a completed burst

Behaviour:
- Reset state (nCLR low, asynchronous):
  - Outputs: CLK_Out=0, tick=0, done=0, busy=0, cfg_ready=1.
  - Internal: state IDLE, counter=0, pulse count=0, no pending config.
  - Active config: half=DEF_HALF, continuous mode, N=0.
- Reset mid-run: everything returns immediately to the reset state; the partial period is lost; done is not asserted.
- Config handshake:
  - Transfer occurs on a rising edge with cfg_valid&cfg_ready; the transfer captures cfg_half/cfg_burst/cfg_pulses into a shadow register and sets pending.
  - cfg_ready = !pending.
  - cfg_half=0 is stored as 1.
- Config apply:
  - IDLE: pending is copied to active on the next edge and pending cleared.
  - RUN/STOPPING: pending is applied only on the edge where CLK_Out falls 1->0. The counter restarts at 0 with the new half.
  - A pending config is also applied on the edge that enters IDLE.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - start=1 and stop=0 -> RUN; counter=0, pulse count=0, CLK_Out stays 0.
  - start and stop both high: stop wins and the block stays IDLE.
  - Burst mode with N=0: start produces done=1 for one cycle and stays IDLE; no CLK_Out activity.
- RUN counter:
  - The counter increments each cycle.
  - When counter==half-1: counter<=0 and CLK_Out toggles.
  - If start is sampled at edge k with half H, CLK_Out rises at edge k+H, falls at k+2H, then repeats with period 2H.
- Rise events:
  - On each 0->1 toggle, tick=1 for exactly that one cycle and pulse count increments (saturating at 2^PULSE_W-1).
- Burst completion:
  - After the Nth rise, the block continues to the following fall.
  - On that falling edge: -> IDLE, done=1 for one cycle.
  - Total burst length: 2·N·H cycles from the start edge.
- Continuous mode: RUN indefinitely; the pulse count is still kept but ignored.
- stop in RUN:
  - If CLK_Out=0, the block enters IDLE on the next edge, counter cleared, no done.
  - If CLK_Out=1, the block enters STOPPING.
- STOPPING: counting continues until the fall toggle; on that edge -> IDLE, no done, no further tick. start is ignored in STOPPING and RUN.
- stop and burst completion on the same edge: the burst completes normally with done=1.
- busy is registered and equals state!=IDLE.
- CLK_Out never changes while in IDLE.

Test Plan:
1. Reset, release nCLR, start=1 one cycle with default half → CLK_Out rises 25000000 cycles later and the tick pulse occurs. Use DEF_HALF=3 override for simulation: rise at +3, fall at +6, period 6.
2. Config half=2 in IDLE, burst=1, N=3; start at edge k → ticks at k+2, k+6, k+10; done=1 at k+12; busy drops at k+12; CLK_Out=0 after.
3. Continuous with half=4 running; push cfg_half=1 while CLK_Out=1 → cfg_ready=0 until the next fall; the old 8-cycle period completes; then the period becomes 2; cfg_ready returns 1.
4. Continuous half=5: assert stop while CLK_Out=1 at counter=1 → CLK_Out falls 3 cycles later, busy=0, done stays 0, no extra tick. Repeat with stop while CLK_Out=0 → IDLE next edge.
5. start and stop high together in IDLE → stays IDLE, busy=0. Burst N=0 start → done one cycle, CLK_Out stays 0.
6. Pull nCLR low mid-burst with CLK_Out=1 and a pending config → all outputs reset immediately; after release, half=DEF_HALF and cfg_ready=1.
